serial_mag_comp: RTL and testbench
==================================

Name: serial_mag_comp

Overview:
- Sequential N-bit magnitude comparator, directly downstream of the 1-bit compare cell; consumes the per-bit greater/equal/less result.
- Loads two WIDTH-bit operands on a start pulse and walks them MSB-first, one bit pair per clock.
- Produces a registered greater/equal/less verdict with a one-cycle done strobe.
- Used where area matters more than latency (datapath sort/select control).

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- CNT_W (localparam), $clog2(WIDTH+1), width of bit counter and bits_used.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_in  in  WIDTH  operand A, captured on accepted start.
- b_in  in  WIDTH  operand B, captured on accepted start.
- busy  out  1  high in SHIFT state.
- done  out  1  one-cycle strobe, high in DONE state.
- g  out  1  A > B, registered.
- e  out  1  A == B, registered.
- l  out  1  A < B, registered.
- bits_used  out  CNT_W  bit pairs examined for the last result.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, {g,e,l}=3'b010, bits_used=0, shift regs cleared. This applies immediately, including mid-operation; the interrupted compare is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1 at an edge, capture a_in/b_in into shift regs, clear counter and sticky verdict, go to SHIFT. Otherwise stay.
- SHIFT (busy=1):
  - Each cycle, feed the MSBs of both shift regs to the bit cell.
  - If the bit result is not equal and no verdict is latched yet, latch it (sticky).
  - Shift both regs left by 1 and increment the counter.
  - Go to DONE after the WIDTH-th bit, or earlier per the optional feature.
- DONE (done=1, busy=0, one cycle only): outputs update on entry.
  - {g,e,l} = sticky verdict, or 3'b010 if no differing bit was found.
  - bits_used = counter.
  - Next state is IDLE unconditionally.
- Latency: start sampled at edge 0; MSB is compared in cycle 1; the full run puts done high in cycle WIDTH+1.
- Exactly one of g/e/l is high at all times.
- Outputs hold their last value until the next DONE, and do not change while busy.
- start is ignored in SHIFT and DONE; no queuing.
- If start is held high continuously, a new operation is accepted in the IDLE cycle following each DONE. Minimum period is WIDTH+2 cycles full run.

Optional Feature:
- Macro: SERIAL_MAG_COMP_EARLY_EXIT_EN.
- Defined: SHIFT goes to DONE in the same cycle the first differing bit is found.
  - If the first difference is at bit p, done is high in cycle WIDTH-p+1.
  - bits_used = WIDTH-p.
- Undefined: always WIDTH bit cycles; done in cycle WIDTH+1; bits_used = WIDTH. The verdict is identical in both builds.

Decomposition:
- Shared package:
  - Result encodings: CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001.
  - State typedef/localparams: ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module cmp_bit_cell: combinational 1-bit compare (a,b -> g,e,l) using the package encodings. Instantiated once on the shift-reg MSBs.

Test Plan (WIDTH=8, cycles counted from the start-sampling edge):
- a=8'hA5, b=8'hA5, start -> done in cycle 9, {g,e,l}=010, bits_used=8, in both builds.
- a=8'h80, b=8'h7F -> {g,e,l}=100.
  - With EARLY_EXIT_EN: done in cycle 2, bits_used=1.
  - Without it: done in cycle 9, bits_used=8.
- a=8'h12, b=8'h13 -> {g,e,l}=001, done in cycle 9, bits_used=8, in both builds.
- Start a=8'h01, b=8'h02; at cycle 3 pulse start with a=8'hFF, b=8'h00 -> second start ignored; result 001.
- rst pulsed in cycle 4 of a compare -> immediately busy=0, done=0, {g,e,l}=010, bits_used=0; next start with 8'h40 vs 8'h20 gives 100.
- start held high, operands 8'h10 vs 8'h10 then 8'h10 vs 8'h11 -> two done strobes 10 cycles apart; outputs hold 010 until the second DONE, then 001.

Source files
------------

// File: rtl/serial_mag_comp_pkg.sv
// Shared definitions for the serial magnitude comparator: verdict encodings and FSM states.
// Verdict is one-hot {g,e,l}; EQ doubles as the "no difference seen yet" value.
// Optional early-exit build is selected with SERIAL_MAG_COMP_EARLY_EXIT_EN.
package serial_mag_comp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_mag_comp_cmp_bit_cell.sv
// Combinational 1-bit compare cell: a vs b -> one-hot {g,e,l}.
// Zero latency, no state.
// No backpressure; purely combinational.
module cmp_bit_cell
  import serial_mag_comp_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic g,
  output logic e,
  output logic l
);

  // One-hot result in the package encoding
  always_comb begin
    {g, e, l} = CMP_EQ;
    if (a && !b) begin
      {g, e, l} = CMP_GT;
    end else if (!a && b) begin
      {g, e, l} = CMP_LT;
    end
  end

endmodule

// File: rtl/serial_mag_comp.sv
// Serial MSB-first magnitude comparator, one bit pair per clock, registered g/e/l verdict.
// Latency: done in cycle WIDTH+1 after the start edge (earlier with SERIAL_MAG_COMP_EARLY_EXIT_EN).
// No queuing: start is only sampled in IDLE and ignored while busy or done.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l,
  output logic [CNT_W-1:0] bits_used
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       sticky_q;
  logic [2:0]       res_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] bits_used_q;

  logic [2:0]       bit_res;
  logic [2:0]       verdict_d;
  logic [CNT_W-1:0] cnt_d;
  logic             finish_d;

  cmp_bit_cell u_cell (
    .a (a_q[WIDTH-1]),
    .b (b_q[WIDTH-1]),
    .g (bit_res[2]),
    .e (bit_res[1]),
    .l (bit_res[0])
  );

  // Verdict so far including this cycle's bit, and whether this is the final SHIFT cycle
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    verdict_d = (sticky_q != CMP_EQ) ? sticky_q : bit_res;
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
    finish_d  = (cnt_q == LAST_CNT) || (bit_res != CMP_EQ);
`else
    finish_d  = (cnt_q == LAST_CNT);
`endif
  end

  // Control FSM with registered outputs; outputs only move on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      sticky_q    <= CMP_EQ;
      res_q       <= CMP_EQ;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bits_used_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            cnt_q    <= '0;
            sticky_q <= CMP_EQ;
            busy_q   <= 1'b1;
            state_q  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // First differing bit wins; later bits cannot override it
          sticky_q <= verdict_d;
          a_q      <= {a_q[WIDTH-2:0], 1'b0};
          b_q      <= {b_q[WIDTH-2:0], 1'b0};
          cnt_q    <= cnt_d;
          if (finish_d) begin
            res_q       <= verdict_d;
            bits_used_q <= cnt_d;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign {g, e, l} = res_q;
  assign bits_used = bits_used_q;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed self-checking bench for serial_mag_comp (WIDTH=8).
// Expectations adapt to SERIAL_MAG_COMP_EARLY_EXIT_EN where the done cycle differs.
// Cycle k is the interval after the k-th rising edge following the start-sampling edge.
module tb_serial_mag_comp;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int LIMIT = 40;

`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
  localparam int GT_CYC  = 2;  // 80 vs 7F, diff at bit 7
  localparam int GT_BITS = 1;
  localparam int IG_CYC  = 8;  // 01 vs 02, diff at bit 1
  localparam int IG_BITS = 7;
  localparam int RM_CYC  = 3;  // 40 vs 20, diff at bit 6
  localparam int RM_BITS = 2;
`else
  localparam int GT_CYC  = 9;
  localparam int GT_BITS = 8;
  localparam int IG_CYC  = 9;
  localparam int IG_BITS = 8;
  localparam int RM_CYC  = 9;
  localparam int RM_BITS = 8;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in, b_in;
  logic             busy, done, g, e, l;
  logic [CNT_W-1:0] bits_used;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .g         (g),
    .e         (e),
    .l         (l),
    .bits_used (bits_used)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start from IDLE and return the cycle in which done is first seen
  task automatic start_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output int cyc);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if ({g, e, l} !== 3'b010) begin n_fail++; $display("FAIL reset_gel got %b want 010", {g, e, l}); end
    n_cmp++; if (bits_used !== 4'd0) begin n_fail++; $display("FAIL reset_bits got %0d want 0", bits_used); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_equal();
    int cyc;
    start_and_wait(8'hA5, 8'hA5, cyc);
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL eq_cycle got %0d want 9", cyc); end
    n_cmp++; if ({g, e, l} !== 3'b010) begin n_fail++; $display("FAIL eq_gel got %b want 010", {g, e, l}); end
    n_cmp++; if (bits_used !== 4'd8) begin n_fail++; $display("FAIL eq_bits got %0d want 8", bits_used); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL eq_busy_at_done got %b want 0", busy); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL eq_done_strobe got %b want 0", done); end
  endtask

  task automatic test_greater();
    int cyc;
    start_and_wait(8'h80, 8'h7F, cyc);
    n_cmp++; if (cyc !== GT_CYC) begin n_fail++; $display("FAIL gt_cycle got %0d want %0d", cyc, GT_CYC); end
    n_cmp++; if ({g, e, l} !== 3'b100) begin n_fail++; $display("FAIL gt_gel got %b want 100", {g, e, l}); end
    n_cmp++; if (bits_used !== 4'(GT_BITS)) begin n_fail++; $display("FAIL gt_bits got %0d want %0d", bits_used, GT_BITS); end
    tick();
  endtask

  task automatic test_less();
    int cyc;
    start_and_wait(8'h12, 8'h13, cyc);
    n_cmp++; if (cyc !== 9) begin n_fail++; $display("FAIL lt_cycle got %0d want 9", cyc); end
    n_cmp++; if ({g, e, l} !== 3'b001) begin n_fail++; $display("FAIL lt_gel got %b want 001", {g, e, l}); end
    n_cmp++; if (bits_used !== 4'd8) begin n_fail++; $display("FAIL lt_bits got %0d want 8", bits_used); end
    tick();
  endtask

  task automatic test_start_ignored();
    int cyc;
    start = 1'b1; a_in = 8'h01; b_in = 8'h02;
    tick();                               // edge 0
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ig_busy_c1 got %b want 1", busy); end
    tick();                               // cycle 2
    n_cmp++; if (bits_used !== 4'd8) begin n_fail++; $display("FAIL ig_hold_bits got %0d want 8", bits_used); end
    tick();                               // cycle 3: stray start
    start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
    tick();
    start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < LIMIT) begin
      tick();
      cyc++;
    end
    n_cmp++; if (cyc !== IG_CYC) begin n_fail++; $display("FAIL ig_cycle got %0d want %0d", cyc, IG_CYC); end
    n_cmp++; if ({g, e, l} !== 3'b001) begin n_fail++; $display("FAIL ig_gel got %b want 001", {g, e, l}); end
    n_cmp++; if (bits_used !== 4'(IG_BITS)) begin n_fail++; $display("FAIL ig_bits got %0d want %0d", bits_used, IG_BITS); end
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ig_no_requeue got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start = 1'b1; a_in = 8'h0F; b_in = 8'h0E;
    tick();
    start = 1'b0;
    tick(); tick(); tick();               // now in cycle 4
    rst = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rm_done got %b want 0", done); end
    n_cmp++; if ({g, e, l} !== 3'b010) begin n_fail++; $display("FAIL rm_gel got %b want 010", {g, e, l}); end
    n_cmp++; if (bits_used !== 4'd0) begin n_fail++; $display("FAIL rm_bits got %0d want 0", bits_used); end
    tick();
    rst = 1'b0;
    tick();
    start_and_wait(8'h40, 8'h20, cyc);
    n_cmp++; if (cyc !== RM_CYC) begin n_fail++; $display("FAIL rm_next_cycle got %0d want %0d", cyc, RM_CYC); end
    n_cmp++; if ({g, e, l} !== 3'b100) begin n_fail++; $display("FAIL rm_next_gel got %b want 100", {g, e, l}); end
    n_cmp++; if (bits_used !== 4'(RM_BITS)) begin n_fail++; $display("FAIL rm_next_bits got %0d want %0d", bits_used, RM_BITS); end
    tick();
  endtask

  task automatic test_back_to_back();
    int d1, d2, ndone;
    d1 = 0; d2 = 0; ndone = 0;
    start = 1'b1; a_in = 8'h10; b_in = 8'h10;
    tick();                               // edge 0
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (cyc == 15) begin
        n_cmp++; if ({g, e, l} !== 3'b010) begin n_fail++; $display("FAIL b2b_hold_gel got %b want 010", {g, e, l}); end
      end
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          d1 = cyc;
          n_cmp++; if ({g, e, l} !== 3'b010) begin n_fail++; $display("FAIL b2b_first_gel got %b want 010", {g, e, l}); end
          b_in = 8'h11;
        end else if (ndone == 2) begin
          d2 = cyc;
          start = 1'b0;
          n_cmp++; if ({g, e, l} !== 3'b001) begin n_fail++; $display("FAIL b2b_second_gel got %b want 001", {g, e, l}); end
        end
      end
      tick();
    end
    n_cmp++; if (ndone !== 2) begin n_fail++; $display("FAIL b2b_strobes got %0d want 2", ndone); end
    n_cmp++; if (d1 !== 9) begin n_fail++; $display("FAIL b2b_first_cycle got %0d want 9", d1); end
    n_cmp++; if (d2 - d1 !== 10) begin n_fail++; $display("FAIL b2b_spacing got %0d want 10", d2 - d1); end
    n_cmp++; if ({g, e, l} !== 3'b001 || busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_final got gel %b busy %b want 001 0", {g, e, l}, busy);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_greater();
    test_less();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
